// File: rtl/multicycle_main_control_if.sv
// Control bus between the multicycle main control FSM and the datapath.
// The controller (master) consumes the opcode and memory handshake and
// drives every datapath enable, mux select and the debug state.
interface multicycle_main_control_if #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
);
    logic [OP_W-1:0] opcode;
    logic            mem_ready;
    logic            PCWrite;
    logic            PCWriteCond;
    logic            IorD;
    logic            MemRead;
    logic            MemWrite;
    logic            IRWrite;
    logic            MemtoReg;
    logic            RegDst;
    logic            RegWrite;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ALUOp;
    logic [1:0]      PCSource;
    logic            illegal_op;
    logic [ST_W-1:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath. Moore outputs decoded
// from the state register, except FETCH PCWrite/IRWrite (follow mem_ready)
// and DECODE illegal_op (follows opcode).
module multicycle_main_control #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input logic                        clk,
    input logic                        reset,
    multicycle_main_control_if.master  bus
);
    localparam logic [ST_W-1:0] S_IDLE   = ST_W'(0);
    localparam logic [ST_W-1:0] S_FETCH  = ST_W'(1);
    localparam logic [ST_W-1:0] S_DECODE = ST_W'(2);
    localparam logic [ST_W-1:0] S_MEMADR = ST_W'(3);
    localparam logic [ST_W-1:0] S_MEMRD  = ST_W'(4);
    localparam logic [ST_W-1:0] S_MEMWB  = ST_W'(5);
    localparam logic [ST_W-1:0] S_MEMWR  = ST_W'(6);
    localparam logic [ST_W-1:0] S_EXEC   = ST_W'(7);
    localparam logic [ST_W-1:0] S_ALUWB  = ST_W'(8);
    localparam logic [ST_W-1:0] S_BRANCH = ST_W'(9);
    localparam logic [ST_W-1:0] S_JUMP   = ST_W'(10);
    localparam logic [ST_W-1:0] S_ADDIEX = ST_W'(11);
    localparam logic [ST_W-1:0] S_ADDIWB = ST_W'(12);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // State register; reset forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection; opcode only matters in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; anything not named for a state stays 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                    default:                                       illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = i_or_d;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.illegal_op  = illegal;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: the driver walks each
// instruction through its expected step list and queues the expected
// state/control word per cycle; the monitor pops and compares on negedge.
module tb_multicycle_main_control;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_main_control_if #(.OP_W(6), .ST_W(4)) bus ();

    multicycle_main_control #(.OP_W(6), .ST_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cycle_no    = 0;

    logic [16:0] dut_ctrl;
    assign dut_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                       bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                       bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                       bus.PCSource, bus.illegal_op};

    // Step numbers of the instruction walk (match the debug state values)
    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4,
                   MEMWB = 5, MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9,
                   JUMP = 10, ADDIEX = 11, ADDIWB = 12;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle_no, act, exp);
        end
    endtask

    // Control word each step should present, straight from the per-step rules
    function automatic logic [16:0] expect_ctrl(input int st, input logic mr, input logic ill);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, il;
        logic [1:0] srcb, aop, pcs;
        pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
        rdst = 0; rw = 0; srca = 0; il = 0; srcb = 0; aop = 0; pcs = 0;
        case (st)
            FETCH:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            DECODE: begin srcb = 2'b11; il = ill; end
            MEMADR: begin srca = 1; srcb = 2'b10; end
            MEMRD:  begin mrd = 1; iord = 1; end
            MEMWB:  begin rw = 1; m2r = 1; end
            MEMWR:  begin mwr = 1; iord = 1; end
            EXEC:   begin srca = 1; aop = 2'b10; end
            ALUWB:  begin rw = 1; rdst = 1; end
            BRANCH: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            JUMP:   begin pcw = 1; pcs = 2'b10; end
            ADDIEX: begin srca = 1; srcb = 2'b10; end
            ADDIWB: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, il};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2b ||
               op == 6'h04 || op == 6'h02 || op == 6'h08;
    endfunction

    // One clock cycle: apply inputs, queue the expectation, advance past the edge
    task automatic step(input int st, input logic [5:0] op, input logic mr, input logic ill);
        exp_t e;
        bus.opcode    = op;
        bus.mem_ready = mr;
        e.st   = 4'(st);
        e.ctrl = expect_ctrl(st, mr, ill);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    // Walk one instruction from FETCH until the machine is back at FETCH
    task automatic run_instr(input logic [5:0] op, input int unsigned fstall, input int unsigned mstall);
        for (int unsigned i = 0; i < fstall; i++) step(FETCH, rnd_op(), 1'b0, 1'b0);
        step(FETCH, rnd_op(), 1'b1, 1'b0);
        step(DECODE, op, rnd_bit(), !is_legal(op));
        case (op)
            6'h00: begin
                step(EXEC, rnd_op(), rnd_bit(), 1'b0);
                step(ALUWB, rnd_op(), rnd_bit(), 1'b0);
            end
            6'h23: begin
                step(MEMADR, op, rnd_bit(), 1'b0);
                for (int unsigned i = 0; i < mstall; i++) step(MEMRD, rnd_op(), 1'b0, 1'b0);
                step(MEMRD, rnd_op(), 1'b1, 1'b0);
                step(MEMWB, rnd_op(), rnd_bit(), 1'b0);
            end
            6'h2b: begin
                step(MEMADR, op, rnd_bit(), 1'b0);
                for (int unsigned i = 0; i < mstall; i++) step(MEMWR, rnd_op(), 1'b0, 1'b0);
                step(MEMWR, rnd_op(), 1'b1, 1'b0);
            end
            6'h04: step(BRANCH, rnd_op(), rnd_bit(), 1'b0);
            6'h02: step(JUMP, rnd_op(), rnd_bit(), 1'b0);
            6'h08: begin
                step(ADDIEX, rnd_op(), rnd_bit(), 1'b0);
                step(ADDIWB, rnd_op(), rnd_bit(), 1'b0);
            end
            default: ;
        endcase
    endtask

    // Monitor: every cycle the DUT presents state and controls; compare with queue head
    always @(negedge clk) begin
        exp_t e;
        cycle_no++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("state", 32'(bus.state), 32'(e.st));
            check("ctrl", 32'(dut_ctrl), 32'(e.ctrl));
        end
    end

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        legal_ops[0] = 6'h00; legal_ops[1] = 6'h23; legal_ops[2] = 6'h2b;
        legal_ops[3] = 6'h04; legal_ops[4] = 6'h02; legal_ops[5] = 6'h08;

        reset         = 1'b1;
        bus.opcode    = '0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Held in reset: everything 0 even with mem_ready high
        step(IDLE, rnd_op(), 1'b1, 1'b0);
        step(IDLE, rnd_op(), 1'b1, 1'b0);
        reset = 1'b0;
        step(IDLE, rnd_op(), 1'b1, 1'b0);

        // Directed instructions
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 3);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h3f, 0, 0);
        run_instr(6'h08, 0, 0);
        run_instr(6'h2b, 2, 1);

        // sw interrupted by reset while stalled in MEMWR
        step(FETCH, rnd_op(), 1'b1, 1'b0);
        step(DECODE, 6'h2b, rnd_bit(), 1'b0);
        step(MEMADR, 6'h2b, rnd_bit(), 1'b0);
        begin
            exp_t e;
            bus.mem_ready = 1'b0;
            e.st   = 4'(MEMWR);
            e.ctrl = expect_ctrl(MEMWR, 1'b0, 1'b0);
            sb_q.push_back(e);
            @(negedge clk);
            #2;
            reset = 1'b1;
            #1;
            check("async_reset_state", 32'(bus.state), 32'(IDLE));
            check("async_reset_memwrite", 32'(bus.MemWrite), 32'd0);
            check("async_reset_ctrl", 32'(dut_ctrl), 32'd0);
            @(posedge clk);
            #1;
        end
        step(IDLE, rnd_op(), 1'b1, 1'b0);
        reset = 1'b0;
        step(IDLE, rnd_op(), 1'b1, 1'b0);
        run_instr(6'h00, 0, 0);

        // Random instruction stream with random stalls
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 5)];
            else                          op = rnd_op();
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
